// File: rtl/countdown_timer_pkg.sv
// Shared widths, terminal values and state encoding for the MM:SS countdown timer.
package countdown_timer_pkg;

    localparam int unsigned BCD_W            = 4;
    localparam int unsigned NUM_DIGITS       = 4;
    localparam int unsigned DIGITS_W         = NUM_DIGITS * BCD_W;
    localparam int unsigned UNITS_MAX        = 9;
    localparam int unsigned TENS_MAX_DEFAULT = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/countdown_timer_bcd_down_digit.sv
// One BCD down-counting digit with clamped load and borrow output.
module bcd_down_digit
    import countdown_timer_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [BCD_W-1:0] load_val,
    input  logic [BCD_W-1:0] max,
    input  logic             en,
    output logic [BCD_W-1:0] value,
    output logic             borrow_out
);

    // Borrow when this digit is asked to step below zero.
    assign borrow_out = en && (value == '0);

    // Digit register: clamped load takes priority over decrement.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= '0;
        end else if (load) begin
            value <= (load_val > max) ? max : load_val;
        end else if (en) begin
            value <= (value == '0) ? max : value - BCD_W'(1);
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Four-digit BCD MM:SS countdown timer with pause/resume and expiry flag.
module countdown_timer #(
    parameter int unsigned SEC_TENS_MAX = 5,
    parameter int unsigned MIN_TENS_MAX = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        load,
    input  logic [15:0] load_value,
    input  logic        start,
    input  logic        pause,
    output logic [15:0] digits,
    output logic        running,
    output logic        done,
    output logic        expired
);
    import countdown_timer_pkg::*;

    localparam logic [BCD_W-1:0] U_MAX  = BCD_W'(UNITS_MAX);
    localparam logic [BCD_W-1:0] ST_MAX = BCD_W'(SEC_TENS_MAX);
    localparam logic [BCD_W-1:0] MT_MAX = BCD_W'(MIN_TENS_MAX);

    state_t           state, state_nx;
    logic             running_nx, done_nx, expired_nx;
    logic [BCD_W-1:0] sec_u, sec_t, min_u, min_t;
    logic             borrow_su, borrow_st, borrow_mu, borrow_mt;
    logic             dec_c;
    logic             hit_zero_c;

    // A qualified tick only counts in RUN with no pause or load pending.
    assign dec_c = (state == RUN) && tick && !pause && !load;

    // Current value 00:01 under a decrement means the next value is 00:00.
    // A borrow out of the top digit could only mean a wrap, so treat it as expiry too.
    assign hit_zero_c = (dec_c && (digits == DIGITS_W'(1))) || borrow_mt;

    assign digits = {min_t, min_u, sec_t, sec_u};

    bcd_down_digit u_sec_units (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_val   (load_value[3:0]),
        .max        (U_MAX),
        .en         (dec_c),
        .value      (sec_u),
        .borrow_out (borrow_su)
    );

    bcd_down_digit u_sec_tens (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_val   (load_value[7:4]),
        .max        (ST_MAX),
        .en         (borrow_su),
        .value      (sec_t),
        .borrow_out (borrow_st)
    );

    bcd_down_digit u_min_units (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_val   (load_value[11:8]),
        .max        (U_MAX),
        .en         (borrow_st),
        .value      (min_u),
        .borrow_out (borrow_mu)
    );

    bcd_down_digit u_min_tens (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_val   (load_value[15:12]),
        .max        (MT_MAX),
        .en         (borrow_mu),
        .value      (min_t),
        .borrow_out (borrow_mt)
    );

    // State and flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            running <= 1'b0;
            done    <= 1'b0;
            expired <= 1'b0;
        end else begin
            state   <= state_nx;
            running <= running_nx;
            done    <= done_nx;
            expired <= expired_nx;
        end
    end

    // Next-state logic; load overrides every state.
    always_comb begin
        state_nx   = state;
        expired_nx = 1'b0;
        if (load) begin
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (digits == '0) begin
                            state_nx   = DONE;
                            expired_nx = 1'b1;
                        end else begin
                            state_nx = RUN;
                        end
                    end
                end
                RUN: begin
                    if (pause) begin
                        state_nx = PAUSE;
                    end else if (hit_zero_c) begin
                        state_nx   = DONE;
                        expired_nx = 1'b1;
                    end
                end
                PAUSE: begin
                    if (start) begin
                        state_nx = RUN;
                    end
                end
                DONE: begin
                    state_nx = DONE;
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end
        running_nx = (state_nx == RUN);
        done_nx    = (state_nx == DONE);
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed plan plus randomized traffic
// against a seconds-remaining reference model.
module tb_countdown_timer;

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;
    localparam int S_DONE  = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        tick, load, start, pause;
    logic [15:0] load_value;
    logic [15:0] digits;
    logic        running, done, expired;

    int n_cmp = 0;
    int n_err = 0;

    int m_secs;
    int m_state;
    bit m_exp;

    countdown_timer dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .load       (load),
        .load_value (load_value),
        .start      (start),
        .pause      (pause),
        .digits     (digits),
        .running    (running),
        .done       (done),
        .expired    (expired)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int min_int(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Preset to seconds remaining, each digit clamped to its terminal.
    function automatic int clamp_secs(input logic [15:0] lv);
        int mt, mu, st, su;
        mt = min_int(int'(lv[15:12]), 5);
        mu = min_int(int'(lv[11:8]), 9);
        st = min_int(int'(lv[7:4]), 5);
        su = min_int(int'(lv[3:0]), 9);
        return (mt * 10 + mu) * 60 + st * 10 + su;
    endfunction

    function automatic logic [15:0] to_bcd(input int secs);
        int m, s;
        m = secs / 60;
        s = secs % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic model_reset();
        m_secs  = 0;
        m_state = S_IDLE;
        m_exp   = 1'b0;
    endtask

    task automatic model_step(input bit ld, input logic [15:0] lv, input bit st,
                              input bit pz, input bit tk);
        m_exp = 1'b0;
        if (ld) begin
            m_secs  = clamp_secs(lv);
            m_state = S_IDLE;
        end else begin
            case (m_state)
                S_IDLE: if (st) begin
                    if (m_secs == 0) begin
                        m_state = S_DONE;
                        m_exp   = 1'b1;
                    end else begin
                        m_state = S_RUN;
                    end
                end
                S_RUN: if (pz) begin
                    m_state = S_PAUSE;
                end else if (tk) begin
                    m_secs = m_secs - 1;
                    if (m_secs == 0) begin
                        m_state = S_DONE;
                        m_exp   = 1'b1;
                    end
                end
                S_PAUSE: if (st) m_state = S_RUN;
                default: ;
            endcase
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".digits"},  digits,        to_bcd(m_secs));
        check({tag, ".running"}, 16'(running),  16'(m_state == S_RUN));
        check({tag, ".done"},    16'(done),     16'(m_state == S_DONE));
        check({tag, ".expired"}, 16'(expired),  16'(m_exp));
    endtask

    // One clock: drive on falling edge, update model at rising edge, sample 1 time unit later.
    task automatic step(input string tag, input bit ld, input logic [15:0] lv,
                        input bit st, input bit pz, input bit tk);
        @(negedge clk);
        load = ld; load_value = lv; start = st; pause = pz; tick = tk;
        @(posedge clk);
        model_step(ld, lv, st, pz, tk);
        #1;
        check_all(tag);
    endtask

    task automatic ticks(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
        load_value = 16'h0;
        model_reset();
        #1;
        check_all("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Plain seconds countdown.
        step("t1_load", 1'b1, 16'h0103, 1'b0, 1'b0, 1'b0);
        step("t1_start", 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        ticks("t1_tick", 3);
        check("t1_lit", digits, 16'h0100);
        check("t1_run", 16'(running), 16'h1);

        // Borrow across minutes and run to expiry.
        step("t2_load", 1'b1, 16'h0100, 1'b0, 1'b0, 1'b0);
        step("t2_start", 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        ticks("t2_tick", 1);
        check("t2_borrow", digits, 16'h0059);
        ticks("t2_run", 59);
        check("t2_expired", 16'(expired), 16'h1);
        check("t2_done", 16'(done), 16'h1);
        ticks("t2_hold", 3);
        check("t2_hold_lit", digits, 16'h0000);

        // Clamped load.
        step("t3_load", 1'b1, 16'h7F9A, 1'b0, 1'b0, 1'b0);
        check("t3_clamp", digits, 16'h5959);
        step("t3_start", 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        ticks("t3_tick", 1);
        check("t3_lit", digits, 16'h5958);

        // Pause beats tick, start beats pause.
        step("t4_load", 1'b1, 16'h0030, 1'b0, 1'b0, 1'b0);
        step("t4_start", 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        step("t4_pz_tk", 1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
        check("t4_paused", digits, 16'h0030);
        ticks("t4_ptick", 5);
        step("t4_resume", 1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
        ticks("t4_tick", 1);
        check("t4_lit", digits, 16'h0029);

        // Start at zero goes straight to DONE.
        step("t5_load", 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
        step("t5_start", 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        check("t5_expired", 16'(expired), 16'h1);
        step("t5_again", 1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
        check("t5_exp_once", 16'(expired), 16'h0);
        step("t5_reload", 1'b1, 16'h0005, 1'b0, 1'b0, 1'b0);
        check("t5_done_clr", 16'(done), 16'h0);

        // Asynchronous reset mid-count.
        step("t6_load", 1'b1, 16'h0012, 1'b0, 1'b0, 1'b0);
        step("t6_start", 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        ticks("t6_tick", 1);
        @(negedge clk);
        load = 1'b0; start = 1'b0; pause = 1'b0; tick = 1'b0;
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all("t6_areset");
        @(negedge clk);
        reset = 1'b0;
        ticks("t6_after", 3);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            bit          ld, st, pz, tk;
            logic [15:0] lv;
            ld = ($urandom_range(0, 99) < 3);
            st = ($urandom_range(0, 99) < 10);
            pz = ($urandom_range(0, 99) < 5);
            tk = ($urandom_range(0, 99) < 40);
            if ($urandom_range(0, 1) == 1) lv = 16'($urandom_range(0, 20));
            else                           lv = 16'($urandom);
            step("rand", ld, lv, st, pz, tk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Four-digit BCD MM:SS down-counter for the stopwatch project; the counting-down counterpart of the up-counting digit chain.
- Loads a preset, decrements once per external 1 Hz `tick`, pauses and resumes on request, and flags expiry at 00:00.
- Sits between the 1 Hz prescaler and the seven-segment display multiplexer; `digits` feeds the display directly.

Parameters:
SEC_TENS_MAX, 5, terminal value of seconds-tens digit (seconds-units terminal fixed at 9)
MIN_TENS_MAX, 5, terminal value of minutes-tens digit (minutes-units terminal fixed at 9)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high; clock clk
tick  input  1  one-clk enable pulse, 1 Hz, from prescaler
load  input  1  load load_value, force IDLE
load_value  input  16  BCD preset {min_tens, min_units, sec_tens, sec_units}
start  input  1  begin/resume countdown (level sampled each clk)
pause  input  1  suspend countdown (level sampled each clk)
digits  output  16  current BCD value, same packing as load_value
running  output  1  high in RUN
done  output  1  high in DONE
expired  output  1  one-clk pulse on entering DONE

Behaviour:
- Reset (async): digits=16'h0000, state=IDLE, running=0, done=0, expired=0.
- States: IDLE, RUN, PAUSE, DONE, encoded in 2 bits; running and done decoded from registered state.
- Priority per clk: reset > load > state logic.
- load in any state:
  - Next edge: digits <= load_value with each digit clamped to its terminal (units >9 -> 9, tens >MAX -> MAX).
  - State -> IDLE; tick, start and pause are ignored that cycle.
- IDLE:
  - start with digits!=0 -> RUN.
  - start with digits==0 -> DONE, expired pulses.
  - tick and pause are ignored.
- RUN:
  - pause -> PAUSE; pause wins over a simultaneous tick, so no decrement that cycle.
  - tick without pause -> decrement by one second:
    - sec_units 0 -> 9 with borrow; sec_tens 0 -> SEC_TENS_MAX with borrow.
    - min_units 0 -> 9 with borrow; min_tens takes the borrow.
  - Decrement result 0000 -> state DONE on the same edge; expired=1 for exactly that one cycle.
  - start in RUN has no effect.
- PAUSE:
  - Digits hold.
  - start -> RUN; start wins over a simultaneous pause.
  - tick is ignored.
- DONE:
  - digits hold 0000; done=1 until load or reset.
  - start, pause and tick are ignored.
- Latency: digits update on the clk edge where tick is sampled high; outputs are registered with no combinational path from inputs.
- Underflow: 00:00 never decrements, because DONE is entered first, so no wrap to 59:59.
- A tick longer than one clk decrements once per high cycle; the prescaler must guarantee a 1-clk pulse.
- Mid-count reset clears everything asynchronously; counting resumes only after load and start.

Decomposition:
- Shared package:
  - State encoding constants IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, DONE=2'd3.
  - BCD_W=4; default terminals 9/5.
- Sub-module `bcd_down_digit`, instantiated 4x:
  - Ports: clk, reset, load, load_val[3:0], max[3:0], en, value[3:0], borrow_out.
  - On load, value <= min(load_val, max).
  - On en: value <= (value==0) ? max : value-1.
  - borrow_out = en && value==0 (combinational).
  - en of each stage = tick_qualified of the first stage ANDed through the borrow chain.
- Top level holds the FSM and the zero-detect on the next value.

Test Plan:
- Reset, then load 16'h0103, start, apply 3 ticks -> digits 0102, 0101, 0100; running=1.
- Load 0100, start, 1 tick -> digits 0059 (borrow across minutes); 59 more ticks -> 0000, expired pulses 1 clk, done=1, running=0; further ticks hold 0000.
- Load 16'h7F9A -> digits 5959 (clamped); start, 1 tick -> 5958.
- RUN at 0030, assert pause and tick in the same clk -> PAUSE, digits stay 0030; 5 ticks -> unchanged; start -> RUN, next tick -> 0029.
- Load 0000, start -> DONE next edge with expired=1 for one clk; start again -> no change; load 0005 -> IDLE, done=0.
- RUN at 0012, assert reset asynchronously between edges -> digits=0000 and all flags 0 immediately; ticks after release -> no change.
